// File: rtl/alu_pkg.sv
// Shared definitions for the switch/enter ALU and its host-side command sequencer.
//   ALU_RES_W       width of the ALU result bus
//   ALU_OP_*        opcode values understood by the ALU
//   seq_state_e     sequencer FSM states
package alu_pkg;

    localparam int unsigned ALU_RES_W = 16;

    localparam logic [7:0] ALU_OP_ADD = 8'h00;
    localparam logic [7:0] ALU_OP_SUB = 8'h01;
    localparam logic [7:0] ALU_OP_MUL = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StEntA,
        StGapA,
        StEntB,
        StGapB,
        StEntOp,
        StWait,
        StResp
    } seq_state_e;

endpackage

// File: rtl/alu_enter_pulse.sv
// One switch/enter entry: a single-cycle enter pulse followed by ENTER_GAP enter-low cycles.
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   start  in   begin an entry; enter is high in the following cycle
//   enter  out  registered enter pulse
//   done   out  high in the last enter-low cycle, so the next entry can start back-to-back
module alu_enter_pulse #(
    parameter int unsigned ENTER_GAP = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic enter,
    output logic done
);

    localparam int unsigned GapW = $clog2(ENTER_GAP + 1);

    logic            enter_q;
    logic [GapW-1:0] gap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enter_q <= 1'b0;
            gap_q   <= '0;
        end else begin
            enter_q <= start;
            if (enter_q) begin
                gap_q <= GapW'(ENTER_GAP);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - 1'b1;
            end
        end
    end

    assign enter = enter_q;
    assign done  = (gap_q == GapW'(1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Host-side driver for the switch/enter ALU. Takes one (A, B, op) command over valid/ready,
// keys it into the ALU as three timed entries, waits RESULT_LAT cycles, captures the result
// and returns it over a valid/ready response channel.
//   clk, rst                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake; cmd_a, cmd_b, cmd_op command fields
//   alu_switch, alu_enter        drive the ALU switch bus and enter strobe
//   alu_result                   ALU result bus
//   rsp_valid/rsp_ready          response handshake; rsp_result captured result
//   busy                         high in every state except idle
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned ENTER_GAP  = 2,
    parameter int unsigned RESULT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_a,
    input  logic [7:0]           cmd_b,
    input  logic [7:0]           cmd_op,
    output logic [7:0]           alu_switch,
    output logic                 alu_enter,
    input  logic [ALU_RES_W-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_RES_W-1:0] rsp_result,
    output logic                 busy
);

    localparam int unsigned WaitW = $clog2(RESULT_LAT + 1);

    seq_state_e           state_q;
    logic [7:0]           switch_q;
    logic [7:0]           b_q;
    logic [7:0]           op_q;
    logic [WaitW-1:0]     wait_q;
    logic                 rsp_valid_q;
    logic [ALU_RES_W-1:0] rsp_result_q;

    logic pulse_start;
    logic pulse_done;

    // Each entry starts in the cycle before its enter pulse, so the next entry is launched
    // from the last gap cycle of the previous one.
    always_comb begin
        pulse_start = 1'b0;
        unique case (state_q)
            StIdle:  pulse_start = cmd_valid;
            StGapA:  pulse_start = pulse_done;
            StGapB:  pulse_start = pulse_done;
            default: pulse_start = 1'b0;
        endcase
    end

    alu_enter_pulse #(
        .ENTER_GAP(ENTER_GAP)
    ) u_enter_pulse (
        .clk  (clk),
        .rst  (rst),
        .start(pulse_start),
        .enter(alu_enter),
        .done (pulse_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            switch_q     <= '0;
            b_q          <= '0;
            op_q         <= '0;
            wait_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        // A goes straight onto the switch bus; B and op wait their turn.
                        switch_q <= cmd_a;
                        b_q      <= cmd_b;
                        op_q     <= cmd_op;
                        state_q  <= StEntA;
                    end
                end
                StEntA: state_q <= StGapA;
                StGapA: begin
                    if (pulse_done) begin
                        switch_q <= b_q;
                        state_q  <= StEntB;
                    end
                end
                StEntB: state_q <= StGapB;
                StGapB: begin
                    if (pulse_done) begin
                        switch_q <= op_q;
                        state_q  <= StEntOp;
                    end
                end
                StEntOp: begin
                    wait_q  <= WaitW'(RESULT_LAT);
                    state_q <= StWait;
                end
                StWait: begin
                    if (wait_q == WaitW'(1)) begin
                        rsp_result_q <= alu_result;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        switch_q    <= '0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated with rst so no command can appear accepted while reset is held.
    assign cmd_ready  = rst && (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign alu_switch = switch_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (default timing and ENTER_GAP=1/RESULT_LAT=4),
// each wired to a behavioural switch/enter ALU. Issued commands go into per-instance queues;
// a negedge monitor pops them on acceptance and checks entry timing, switch values and the
// returned result against the timing rules and plain arithmetic.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  op;
        logic [15:0] res;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid  [2];
    logic        cmd_ready  [2];
    logic [7:0]  cmd_a      [2];
    logic [7:0]  cmd_b      [2];
    logic [7:0]  cmd_op     [2];
    logic [7:0]  alu_switch [2];
    logic        alu_enter  [2];
    logic [15:0] alu_res    [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [15:0] rsp_result [2];
    logic        busy       [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    cmd_t exp_q0[$];
    cmd_t exp_q1[$];
    cmd_t cur       [2];
    bit   active    [2];
    int   t_acc     [2];
    int   done_cnt  [2];
    bit   rr_rand = 1'b0;
    bit   rr_force  [2];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .alu_switch(alu_switch[0]),
        .alu_enter(alu_enter[0]), .alu_result(alu_res[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]), .busy(busy[0])
    );

    alu_cmd_sequencer #(.ENTER_GAP(1), .RESULT_LAT(4)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .alu_switch(alu_switch[1]),
        .alu_enter(alu_enter[1]), .alu_result(alu_res[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]), .busy(busy[1])
    );

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] op);
        case (op)
            ALU_OP_ADD: return {8'h00, a} + {8'h00, b};
            ALU_OP_SUB: return {8'h00, a} - {8'h00, b};
            ALU_OP_MUL: return {8'h00, a} * {8'h00, b};
            default:    return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, got, want);
        end
    endtask

    // Behavioural switch/enter ALU: entries A, B, op; result valid lat_of(k) cycles after the
    // op-entry cycle, with a corrupted value before that so early sampling is caught.
    int          ent_n [2];
    logic [7:0]  ra    [2];
    logic [7:0]  rb    [2];
    logic [15:0] pend  [2];
    int          cnt   [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                ent_n[k]   <= 0;
                cnt[k]     <= 0;
                alu_res[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (alu_enter[k]) begin
                    if (ent_n[k] == 0) ra[k] <= alu_switch[k];
                    else if (ent_n[k] == 1) rb[k] <= alu_switch[k];
                    else begin
                        pend[k]    <= alu_ref(ra[k], rb[k], alu_switch[k]);
                        alu_res[k] <= ~alu_ref(ra[k], rb[k], alu_switch[k]);
                        cnt[k]     <= lat_of(k) - 1;
                    end
                    ent_n[k] <= (ent_n[k] == 2) ? 0 : ent_n[k] + 1;
                end else if (cnt[k] != 0) begin
                    cnt[k] <= cnt[k] - 1;
                    if (cnt[k] == 1) alu_res[k] <= pend[k];
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            rsp_ready[k] = rr_rand ? ($urandom_range(0, 3) != 0) : rr_force[k];
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        int   t, g, l;
        logic exp_ent;
        logic [7:0] exp_sw;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                active[k] = 1'b0;
                chk("rst_enter", k, 32'(alu_enter[k]), 0);
                chk("rst_switch", k, 32'(alu_switch[k]), 0);
                chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 0);
                chk("rst_rsp_result", k, 32'(rsp_result[k]), 0);
                chk("rst_busy", k, 32'(busy[k]), 0);
            end else if (active[k]) begin
                t = t_acc[k];
                g = gap_of(k);
                l = lat_of(k);
                exp_ent = (cyc == t + 1) || (cyc == t + 2 + g) || (cyc == t + 3 + 2 * g);
                if (cyc <= t + 1 + g) exp_sw = cur[k].a;
                else if (cyc <= t + 2 + 2 * g) exp_sw = cur[k].b;
                else exp_sw = cur[k].op;
                chk("busy_active", k, 32'(busy[k]), 1);
                chk("cmd_ready_busy", k, 32'(cmd_ready[k]), 0);
                if (exp_ent || alu_enter[k]) chk("enter_timing", k, 32'(alu_enter[k]), 32'(exp_ent));
                if (cyc <= t + 3 + 2 * g + l) chk("switch", k, 32'(alu_switch[k]), 32'(exp_sw));
                if ((cyc >= t + 4 + 2 * g + l) || rsp_valid[k])
                    chk("rsp_valid_timing", k, 32'(rsp_valid[k]), 32'(cyc >= t + 4 + 2 * g + l));
                if (rsp_valid[k]) chk("rsp_result", k, 32'(rsp_result[k]), 32'(cur[k].res));
                if (rsp_valid[k] && rsp_ready[k]) begin
                    active[k] = 1'b0;
                    done_cnt[k]++;
                end
            end else begin
                chk("idle_busy", k, 32'(busy[k]), 0);
                chk("idle_cmd_ready", k, 32'(cmd_ready[k]), 1);
                chk("idle_enter", k, 32'(alu_enter[k]), 0);
                chk("idle_rsp_valid", k, 32'(rsp_valid[k]), 0);
                chk("idle_switch", k, 32'(alu_switch[k]), 0);
                if (cmd_valid[k]) begin
                    if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        chk("accept_without_cmd", k, 1, 0);
                    end else begin
                        cur[k]    = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        active[k] = 1'b1;
                        t_acc[k]  = cyc;
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op);
        cmd_t it;
        bit   ok;
        it.a   = a;
        it.b   = b;
        it.op  = op;
        it.res = alu_ref(a, b, op);
        if (k == 0) exp_q0.push_back(it);
        else exp_q1.push_back(it);
        cmd_a[k]     = a;
        cmd_b[k]     = b;
        cmd_op[k]    = op;
        cmd_valid[k] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (cmd_ready[k]) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", k, 0, 1);
        @(posedge clk);
        #1;
        cmd_valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            #1;
            if (!active[k] && (k == 0 ? exp_q0.size() : exp_q1.size()) == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", k, 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_a[k]     = 8'h00;
            cmd_b[k]     = 8'h00;
            cmd_op[k]    = 8'h00;
            rsp_ready[k] = 1'b1;
            rr_force[k]  = 1'b1;
            active[k]    = 1'b0;
            done_cnt[k]  = 0;
        end

        // Reset held for 100 ns with a command pulse that must be ignored.
        cycles(2);
        cmd_valid[0] = 1'b1;
        cmd_a[0]     = 8'hAA;
        cycles(1);
        cmd_valid[0] = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(2);

        // ADD with rsp_ready high.
        send(0, 8'h12, 8'h34, ALU_OP_ADD);
        wait_idle(0);

        // MUL with 5 cycles of response backpressure.
        rr_force[0] = 1'b0;
        send(0, 8'hFF, 8'hFF, ALU_OP_MUL);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (rsp_valid[0]) seen = 1'b1;
        end
        if (!seen) chk("mul_rsp_timeout", 0, 0, 1);
        cycles(5);
        rr_force[0] = 1'b1;
        wait_idle(0);

        // Second command raised while busy; held until accepted.
        send(0, 8'h20, 8'h05, ALU_OP_SUB);
        cycles(1);
        send(0, 8'h01, 8'h02, ALU_OP_ADD);
        wait_idle(0);

        // Reset during GAP_B aborts the command; next ADD must be clean.
        send(0, 8'h55, 8'h66, ALU_OP_ADD);
        cycles(4);
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        send(0, 8'h03, 8'h04, ALU_OP_ADD);
        wait_idle(0);
        chk("directed_rsp_count", 0, 32'(done_cnt[0]), 5);

        // Random traffic on both instances with random response backpressure.
        rr_rand = 1'b1;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    cycles($urandom_range(0, 3));
                    send(1, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 2)));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    cycles($urandom_range(0, 3));
                    send(0, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 2)));
                end
            end
        join
        wait_idle(0);
        wait_idle(1);
        rr_rand = 1'b0;
        chk("random_rsp_count", 1, 32'(done_cnt[1]), 120);
        chk("total_rsp_count", 0, 32'(done_cnt[0]), 45);
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
